dcache_mem_arbiter: RTL and testbench
=====================================

DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 8, words per cache-line burst.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_read_req input 1, i_read_addr input 32: icache line-fill request and line address.
REQ-005 SHALL have ports i_read_data output 32, i_read_val output 1: icache fill word and its one-cycle strobe.
REQ-006 SHALL have ports d_write_req input 1, d_write_addr input 32, d_write_data input 32: dcache write-back request, line address, current word.
REQ-007 SHALL have port d_write_val  output  1  one-cycle strobe per word written to memory.
REQ-008 SHALL have ports d_read_req input 1, d_read_addr input 32, d_read_data output 32, d_read_val output 1: dcache line fill.
REQ-009 SHALL have ports ram_en output 1, ram_we output 1, ram_addr output 32, ram_wdata output 32: word request to backing memory.
REQ-010 SHALL have ports ram_rdata input 32, ram_ack input 1: memory completion; ram_rdata valid in ack cycle.

Function
REQ-011 SHALL grant one client per burst, fixed priority d_write > d_read > i_read, evaluated only in IDLE.
REQ-012 SHALL hold the grant for exactly BLOCK_SIZE beats; requests from other clients are ignored until return to IDLE.
REQ-013 SHALL use states IDLE, GAP1, GAP2, ACCESS, DONE1, DONE2.
REQ-014 Transitions: IDLE->GAP1 on any req; GAP1->GAP2; GAP2->ACCESS; ACCESS->GAP1 on ram_ack with beat<BLOCK_SIZE-1; ACCESS->DONE1 on ram_ack with last beat; DONE1->DONE2->IDLE.
REQ-015 The two GAP cycles SHALL be unconditional, giving the client's registered write-data path time to present the next word.
REQ-016 The two DONE cycles SHALL ignore all requests, covering the client's request de-assertion latency after its final strobe.
REQ-017 ram_en SHALL be high only in ACCESS, held with stable ram_addr/ram_we/ram_wdata until ram_ack; ram_ack outside ACCESS SHALL be ignored.
REQ-018 ram_addr SHALL be {granted_addr[31:5], beat[2:0], 2'b00}; beat counts 0..BLOCK_SIZE-1, wraps to 0 on DONE1.
REQ-019 ram_we SHALL be 1 only for a d_write grant; ram_wdata SHALL be d_write_data passed through during ACCESS.
REQ-020 On each ram_ack the strobe for the granted client SHALL pulse for one cycle in the next cycle; read data register SHALL load ram_rdata in that same cycle.
REQ-021 i_read_data and d_read_data SHALL both show the read data register; only the granted client's val strobes.
REQ-022 Memory latency SHALL be arbitrary (ack >= 1 cycle after ram_en rises); no timeout.
REQ-023 If the granted req is low in GAP1 or GAP2, SHALL return to IDLE without issuing further beats; beat resets to 0.
REQ-024 Simultaneous requests in IDLE SHALL resolve per REQ-011; losing requests stay pending with no loss.

Reset
REQ-025 On reset SHALL go to IDLE, beat=0, grant=none, including mid-burst; any in-flight ack is discarded.
REQ-026 Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, i_read_val=0, d_read_val=0, d_write_val=0, i_read_data=0, d_read_data=0.

Verification
REQ-027 d_read_req, addr 0x00001234, ack latency 1, rdata=addr -> ram_addr 0x1220..0x123C in order, 8 d_read_val pulses carrying those values, then DONE1/DONE2/IDLE.
REQ-028 d_write_req then d_read_req (dirty eviction), write addr 0x00002000 -> 8 ram_we beats at 0x2000..0x201C with per-beat d_write_data, 8 d_write_val, then read burst starts after DONE2.
REQ-029 i_read_req and d_read_req raised same cycle -> dcache burst first; icache granted first IDLE after DONE2; no i_read_val during dcache burst.
REQ-030 Ack latency 3 cycles -> ram_en/ram_addr held 3 cycles per beat; exactly one val pulse per ack.
REQ-031 Reset asserted at beat 4 of icache fill -> next cycle all outputs 0, IDLE; reissued req restarts at beat 0.
REQ-032 Granted req dropped in GAP1 after beat 2 -> no further ram_en; arbiter back in IDLE next cycle.

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Burst arbiter that shares one word-wide memory port between icache fills,
// dcache fills and dcache write-backs; each grant covers a full cache line.
module dcache_mem_arbiter #(
  parameter int BLOCK_SIZE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read_req,
  input  logic [31:0] i_read_addr,
  output logic [31:0] i_read_data,
  output logic        i_read_val,
  input  logic        d_write_req,
  input  logic [31:0] d_write_addr,
  input  logic [31:0] d_write_data,
  output logic        d_write_val,
  input  logic        d_read_req,
  input  logic [31:0] d_read_addr,
  output logic [31:0] d_read_data,
  output logic        d_read_val,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam int BW = (BLOCK_SIZE > 8) ? $clog2(BLOCK_SIZE) : 3;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);
  localparam logic [BW-1:0] BEAT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, GAP1, GAP2, ACCESS, DONE1, DONE2} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_DW, GNT_DR, GNT_IR} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [26:0]   line_q, line_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          i_val_q, i_val_d;
  logic          dr_val_q, dr_val_d;
  logic          dw_val_q, dw_val_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          granted_req_s;
  logic          unused_addr_bits_s;

  // Word offsets come from the beat counter, so the low request address bits are never needed
  assign unused_addr_bits_s = ^{i_read_addr[4:0], d_read_addr[4:0], d_write_addr[4:0]};

  // Next-state, grant, beat counter and registered-output computation
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    beat_d        = beat_q;
    line_d        = line_q;
    rdata_d       = rdata_q;
    i_val_d       = 1'b0;
    dr_val_d      = 1'b0;
    dw_val_d      = 1'b0;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    granted_req_s = 1'b0;

    case (grant_q)
      GNT_DW:  granted_req_s = d_write_req;
      GNT_DR:  granted_req_s = d_read_req;
      GNT_IR:  granted_req_s = i_read_req;
      default: granted_req_s = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        beat_d = BEAT_ZERO;
        if (d_write_req) begin
          grant_d = GNT_DW;
          line_d  = d_write_addr[31:5];
          state_d = GAP1;
        end else if (d_read_req) begin
          grant_d = GNT_DR;
          line_d  = d_read_addr[31:5];
          state_d = GAP1;
        end else if (i_read_req) begin
          grant_d = GNT_IR;
          line_d  = i_read_addr[31:5];
          state_d = GAP1;
        end else begin
          grant_d = GNT_NONE;
          state_d = IDLE;
        end
      end
      // A client that withdraws its request during a gap abandons the rest of the line
      GAP1, GAP2: begin
        if (granted_req_s) begin
          state_d = (state_q == GAP1) ? GAP2 : ACCESS;
        end else begin
          state_d = IDLE;
          grant_d = GNT_NONE;
          beat_d  = BEAT_ZERO;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          rdata_d = ram_rdata;
          case (grant_q)
            GNT_DW:  dw_val_d = 1'b1;
            GNT_DR:  dr_val_d = 1'b1;
            GNT_IR:  i_val_d  = 1'b1;
            default: i_val_d  = 1'b0;
          endcase
          if (beat_q == LAST_BEAT) begin
            beat_d  = BEAT_ZERO;
            state_d = DONE1;
          end else begin
            beat_d  = beat_q + BEAT_ONE;
            state_d = GAP1;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      DONE1: state_d = DONE2;
      DONE2: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
        beat_d  = BEAT_ZERO;
      end
    endcase

    // Memory request is captured on entry to ACCESS and held until the ack
    if (state_d == ACCESS) begin
      ram_en_d = 1'b1;
      ram_we_d = (grant_q == GNT_DW);
      if (state_q != ACCESS) begin
        ram_addr_d  = {line_q, beat_q[2:0], 2'b00};
        ram_wdata_d = d_write_data;
      end else begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
      end
    end else begin
      ram_en_d = 1'b0;
      ram_we_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      beat_q      <= BEAT_ZERO;
      line_q      <= 27'd0;
      rdata_q     <= 32'd0;
      i_val_q     <= 1'b0;
      dr_val_q    <= 1'b0;
      dw_val_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      i_val_q     <= i_val_d;
      dr_val_q    <= dr_val_d;
      dw_val_q    <= dw_val_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign i_read_data = rdata_q;
  assign d_read_data = rdata_q;
  assign i_read_val  = i_val_q;
  assign d_read_val  = dr_val_q;
  assign d_write_val = dw_val_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Bench for dcache_mem_arbiter: table of single-client bursts, then hand-written
// priority, eviction, reset and abort sequences against a latency-programmable memory.
module tb_dcache_mem_arbiter;

  localparam int BS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_read_req = 1'b0, d_read_req = 1'b0, d_write_req = 1'b0;
  logic [31:0] i_read_addr = 32'd0, d_read_addr = 32'd0, d_write_addr = 32'd0;
  logic [31:0] d_write_data = 32'd0;
  logic [31:0] i_read_data, d_read_data;
  logic        i_read_val, d_read_val, d_write_val;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic        ram_ack = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  dcache_mem_arbiter #(.BLOCK_SIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .i_read_data(i_read_data), .i_read_val(i_read_val),
    .d_write_req(d_write_req), .d_write_addr(d_write_addr),
    .d_write_data(d_write_data), .d_write_val(d_write_val),
    .d_read_req(d_read_req), .d_read_addr(d_read_addr),
    .d_read_data(d_read_data), .d_read_val(d_read_val),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } exp_req_t;
  typedef struct { logic [2:0] code; logic [31:0] data; } exp_val_t;
  typedef struct { int client; logic [31:0] addr; int lat; logic [31:0] base; } vec_t;

  exp_req_t    req_q[$];
  exp_val_t    val_q[$];
  int          gaps[$];
  int          total = 0, bad = 0;
  int          lat = 1, cnt_mem = 0, cyc = 0, last_val_cyc = 0, rises = 0, wbeat = 0;
  int          vcnt[3] = '{0, 0, 0};
  logic        stray = 1'b0, prev_en = 1'b0, held_we = 1'b0;
  logic [31:0] held_addr = 32'd0, held_wdata = 32'd0;
  exp_req_t    r_m;
  exp_val_t    v_m;
  logic [2:0]  code_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Memory model, request/strobe scoreboard and write-data client, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (i_read_val || d_read_val || d_write_val) begin
      code_m       = {i_read_val, d_read_val, d_write_val};
      last_val_cyc = cyc;
      if (val_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got %b want none", code_m);
      end else begin
        v_m = val_q.pop_front();
        check("strobe_client", 32'(code_m), 32'(v_m.code));
        if (v_m.code != 3'b001) begin
          check("i_read_data", i_read_data, v_m.data);
          check("d_read_data", d_read_data, v_m.data);
        end
      end
      if (i_read_val)  vcnt[0]++;
      if (d_read_val)  vcnt[1]++;
      if (d_write_val) begin vcnt[2]++; wbeat++; end
    end
    if (!d_write_req) wbeat = 0;
    d_write_data = 32'hC0DE_0000 | 32'(wbeat);

    if (ram_en) begin
      if (!prev_en) begin
        rises++;
        gaps.push_back(cyc - last_val_cyc);
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ram_en: got addr %h want none", ram_addr);
        end else begin
          r_m = req_q.pop_front();
          check("ram_addr", ram_addr, r_m.addr);
          check("ram_we", 32'(ram_we), 32'(r_m.we));
          if (r_m.we) check("ram_wdata", ram_wdata, r_m.wdata);
        end
        held_addr = ram_addr; held_we = ram_we; held_wdata = ram_wdata;
      end else begin
        check("ram_addr_hold", ram_addr, held_addr);
        check("ram_we_hold", 32'(ram_we), 32'(held_we));
        check("ram_wdata_hold", ram_wdata, held_wdata);
      end
      cnt_mem++;
    end else begin
      cnt_mem = 0;
    end
    prev_en   = ram_en;
    ram_ack   = (ram_en && cnt_mem == lat) || stray;
    ram_rdata = ram_ack ? ram_addr : 32'hDEAD_BEEF;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic set_req(input int c, input logic v, input logic [31:0] a);
    case (c)
      0:       begin i_read_req = v;  i_read_addr = a;  end
      1:       begin d_read_req = v;  d_read_addr = a;  end
      default: begin d_write_req = v; d_write_addr = a; end
    endcase
  endtask

  task automatic push_burst(input int c, input logic [31:0] base, input int n);
    exp_req_t r;
    exp_val_t v;
    for (int k = 0; k < n; k++) begin
      r.addr = base + 32'(4 * k); r.we = (c == 2); r.wdata = 32'hC0DE_0000 | 32'(k);
      v.code = code_of(c); v.data = base + 32'(4 * k);
      req_q.push_back(r);
      val_q.push_back(v);
    end
  endtask

  task automatic wait_cnt(input int c, input int target, input int budget);
    int n = 0;
    while (vcnt[c] < target && n < budget) begin tick(1); n++; end
    total++;
    if (vcnt[c] < target) begin
      bad++;
      $display("FAIL wait_client%0d: got %0d strobes want %0d", c, vcnt[c], target);
    end
  endtask

  // Two clients raised in the same cycle; c1 must own the first line
  task automatic run_pair(input int c1, input logic [31:0] a1, input logic [31:0] b1,
                          input int c2, input logic [31:0] a2, input logic [31:0] b2);
    int s1 = vcnt[c1], s2 = vcnt[c2], r0 = rises;
    push_burst(c1, b1, BS);
    push_burst(c2, b2, BS);
    set_req(c1, 1'b1, a1);
    set_req(c2, 1'b1, a2);
    wait_cnt(c1, s1 + BS, 300);
    set_req(c1, 1'b0, a1);
    wait_cnt(c2, s2 + BS, 300);
    set_req(c2, 1'b0, a2);
    tick(4);
    check("second_grant_gap", 32'(gaps[r0 + BS]), 32'd5);
  endtask

  initial begin
    vec_t vecs[5];
    int   start, r0, n;
    vecs[0] = '{1, 32'h0000_1234, 1, 32'h0000_1220};
    vecs[1] = '{0, 32'hFFFF_FFFF, 2, 32'hFFFF_FFE0};
    vecs[2] = '{2, 32'h0000_2000, 1, 32'h0000_2000};
    vecs[3] = '{0, 32'h0000_0047, 3, 32'h0000_0040};
    vecs[4] = '{1, 32'h8000_001C, 4, 32'h8000_0000};

    tick(3);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_vals", 32'({i_read_val, d_read_val, d_write_val}), 32'd0);
    check("rst_i_data", i_read_data, 32'd0);
    check("rst_d_data", d_read_data, 32'd0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      lat   = vecs[i].lat;
      start = vcnt[vecs[i].client];
      r0    = rises;
      push_burst(vecs[i].client, vecs[i].base, BS);
      set_req(vecs[i].client, 1'b1, vecs[i].addr);
      wait_cnt(vecs[i].client, start + BS, 400);
      set_req(vecs[i].client, 1'b0, vecs[i].addr);
      tick(4);
      check("vec_beats", 32'(rises - r0), 32'(BS));
      check("vec_queues_empty", 32'(req_q.size() + val_q.size()), 32'd0);
    end

    // Dirty eviction: write-back wins, refill follows
    lat = 1;
    run_pair(2, 32'h0000_2000, 32'h0000_2000, 1, 32'h0000_5010, 32'h0000_5000);
    // Same-cycle icache and dcache fills
    run_pair(1, 32'h0000_0900, 32'h0000_0900, 0, 32'h0000_0700, 32'h0000_0700);
    check("pair_queues_empty", 32'(req_q.size() + val_q.size()), 32'd0);

    // Reset while beat 4 of an icache fill is outstanding
    lat   = 3;
    start = vcnt[0];
    push_burst(0, 32'h0000_4400, BS);
    set_req(0, 1'b1, 32'h0000_4410);
    wait_cnt(0, start + 4, 300);
    n = 0;
    while (!ram_en && n < 20) begin tick(1); n++; end
    check("beat4_ram_en", 32'(ram_en), 32'd1);
    reset = 1'b1;
    set_req(0, 1'b0, 32'h0000_4410);
    tick(1);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_ram_addr", ram_addr, 32'd0);
    check("mid_rst_ram_wdata", ram_wdata, 32'd0);
    check("mid_rst_i_data", i_read_data, 32'd0);
    check("mid_rst_vals", 32'({i_read_val, d_read_val, d_write_val}), 32'd0);
    reset = 1'b0;
    req_q.delete();
    val_q.delete();
    tick(2);
    start = vcnt[0];
    push_burst(0, 32'h0000_4400, BS);
    set_req(0, 1'b1, 32'h0000_4410);
    wait_cnt(0, start + BS, 400);
    set_req(0, 1'b0, 32'h0000_4410);
    tick(4);
    check("restart_queues_empty", 32'(req_q.size() + val_q.size()), 32'd0);

    // Request withdrawn in GAP1 after beat 2; a new client is accepted right away
    lat   = 1;
    start = vcnt[0];
    r0    = rises;
    push_burst(0, 32'h0000_0300, 3);
    set_req(0, 1'b1, 32'h0000_0300);
    wait_cnt(0, start + 3, 200);
    set_req(0, 1'b0, 32'h0000_0300);
    tick(1);
    push_burst(1, 32'h0000_0600, BS);
    set_req(1, 1'b1, 32'h0000_0600);
    wait_cnt(1, vcnt[1] + BS, 300);
    set_req(1, 1'b0, 32'h0000_0600);
    tick(4);
    check("drop_no_more_i", 32'(vcnt[0] - start), 32'd3);
    check("drop_to_idle_gap", 32'(gaps[r0 + 3]), 32'd4);
    check("drop_queues_empty", 32'(req_q.size() + val_q.size()), 32'd0);

    // Acks arriving while idle must be ignored
    r0    = rises;
    n     = vcnt[0] + vcnt[1] + vcnt[2];
    stray = 1'b1;
    tick(4);
    stray = 1'b0;
    tick(3);
    check("stray_ack_strobes", 32'(vcnt[0] + vcnt[1] + vcnt[2]), 32'(n));
    check("stray_ack_ram_en", 32'(rises), 32'(r0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
